// File: rtl/fp32_divider_seq.sv
// fp32_divider_seq: iterative FP32 divider, one quotient bit per clock.
// Hidden-1 mantissas, truncation, zero result with flag on over/underflow.
module fp32_divider_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] out,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic        underflow,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_sign;
    logic [7:0]  r_ea;
    logic [7:0]  r_eb;
    logic [24:0] r_mb;
    logic [24:0] r_rem;
    logic [24:0] r_q;
    logic        r_za;
    logic        r_zb;
    logic [4:0]  r_cnt;

    logic [31:0] r_out;
    logic        r_done;
    logic        r_ovf;
    logic        r_unf;
    logic        r_dz;

    logic        w_ge;
    logic [24:0] w_sub;
    logic [9:0]  w_e;
    logic [22:0] w_frac;
    logic        w_ovf;
    logic        w_unf;

    assign w_ge   = (r_rem >= r_mb);
    assign w_sub  = r_rem - r_mb;
    assign w_e    = {2'b00, r_ea} - {2'b00, r_eb}
                  + (r_q[24] ? 10'd127 : 10'd126);
    assign w_frac = r_q[24] ? r_q[23:1] : r_q[22:0];
    // Signed 10-bit exponent: bit 9 set means negative.
    assign w_ovf  = !w_e[9] && (w_e[8:0] >= 9'd255);
    assign w_unf  = w_e[9] || (w_e == 10'd0);

    assign out         = r_out;
    assign done        = r_done;
    assign overflow    = r_ovf;
    assign underflow   = r_unf;
    assign div_by_zero = r_dz;
    assign busy        = (r_state != IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic: fixed 25 DIV cycles, then one NORM cycle.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next = DIV;
            DIV:     if (r_cnt == 5'd24) w_next = NORM;
            NORM:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Operand capture, restoring iteration and result packing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sign <= 1'b0;
            r_ea   <= '0;
            r_eb   <= '0;
            r_mb   <= '0;
            r_rem  <= '0;
            r_q    <= '0;
            r_za   <= 1'b0;
            r_zb   <= 1'b0;
            r_cnt  <= '0;
            r_out  <= '0;
            r_done <= 1'b0;
            r_ovf  <= 1'b0;
            r_unf  <= 1'b0;
            r_dz   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sign <= A[31] ^ B[31];
                        r_ea   <= A[30:23];
                        r_eb   <= B[30:23];
                        r_rem  <= {2'b01, A[22:0]};
                        r_mb   <= {2'b01, B[22:0]};
                        r_q    <= '0;
                        r_za   <= (A[30:0] == 31'd0);
                        r_zb   <= (B[30:0] == 31'd0);
                        r_cnt  <= '0;
                    end
                end
                DIV: begin
                    if (w_ge) begin
                        r_q   <= {r_q[23:0], 1'b1};
                        r_rem <= {w_sub[23:0], 1'b0};
                    end else begin
                        r_q   <= {r_q[23:0], 1'b0};
                        r_rem <= {r_rem[23:0], 1'b0};
                    end
                    r_cnt <= r_cnt + 5'd1;
                end
                NORM: begin
                    r_done <= 1'b1;
                    r_out  <= '0;
                    r_ovf  <= 1'b0;
                    r_unf  <= 1'b0;
                    r_dz   <= 1'b0;
                    if (r_zb)       r_dz  <= 1'b1;
                    else if (r_za)  r_out <= '0;
                    else if (w_ovf) r_ovf <= 1'b1;
                    else if (w_unf) r_unf <= 1'b1;
                    else            r_out <= {r_sign, w_e[7:0], w_frac};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_divider_seq.sv
// tb_fp32_divider_seq: table vectors, random ops against an integer
// quotient model, and handshake/reset corner sequences.
module tb_fp32_divider_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] out;
    logic        busy;
    logic        done;
    logic        overflow;
    logic        underflow;
    logic        div_by_zero;

    int n_pass;
    int n_total;

    fp32_divider_seq dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .A(A),
        .B(B),
        .out(out),
        .busy(busy),
        .done(done),
        .overflow(overflow),
        .underflow(underflow),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] o;
        logic [2:0]  f;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Reference: quotient from integer division, then exponent rules.
    task automatic model(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] o, output logic [2:0] f);
        longint unsigned ma, mb, q;
        int e;
        logic [22:0] frac;
        ma = {40'd0, 1'b1, a[22:0]};
        mb = {40'd0, 1'b1, b[22:0]};
        q  = (ma << 24) / mb;
        e  = int'(a[30:23]) - int'(b[30:23]) + 126;
        if (q >= 64'd16777216) begin
            e += 1;
            frac = 23'((q >> 1) & 64'h7FFFFF);
        end else begin
            frac = 23'(q & 64'h7FFFFF);
        end
        o = 32'd0;
        f = 3'b000;
        if (b[30:0] == 31'd0)      f = 3'b001;
        else if (a[30:0] == 31'd0) f = 3'b000;
        else if (e >= 255)         f = 3'b100;
        else if (e <= 0)           f = 3'b010;
        else o = {a[31] ^ b[31], 8'(e), frac};
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] o, output logic [2:0] f,
                         output int lat, output logic bok);
        @(negedge clk);
        A = a;
        B = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        A = $urandom;
        B = $urandom;
        lat = 0;
        bok = 1'b1;
        while (!done && lat < 40) begin
            if (!busy) bok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        if (busy) bok = 1'b0;
        o = out;
        f = {overflow, underflow, div_by_zero};
    endtask

    logic [31:0] o, eo;
    logic [2:0]  f, ef;
    logic        bok;
    int          lat;
    logic [31:0] ra, rb;
    int          saw_done;

    initial begin
        n_pass = 0;
        n_total = 0;
        rst_n = 1'b0;
        start = 1'b0;
        A = '0;
        B = '0;

        tbl[0] = '{32'h40C00000, 32'h40000000, 32'h40400000, 3'b000};
        tbl[1] = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 3'b000};
        tbl[2] = '{32'hC0C00000, 32'h40000000, 32'hC0400000, 3'b000};
        tbl[3] = '{32'h7F000000, 32'h3F000000, 32'h00000000, 3'b100};
        tbl[4] = '{32'h00800000, 32'h40000000, 32'h00000000, 3'b010};
        tbl[5] = '{32'h3F800000, 32'h80000000, 32'h00000000, 3'b001};
        tbl[6] = '{32'h00000000, 32'h40000000, 32'h00000000, 3'b000};

        #12;
        chk("reset_out", out, 32'd0);
        chk("reset_ctl", {29'd0, busy, done, overflow | underflow | div_by_zero},
            32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            do_op(tbl[i].a, tbl[i].b, o, f, lat, bok);
            chk($sformatf("tbl%0d_out", i), o, tbl[i].o);
            chk($sformatf("tbl%0d_flags", i), {29'd0, f}, {29'd0, tbl[i].f});
            chk($sformatf("tbl%0d_latency", i), lat, 26);
            chk($sformatf("tbl%0d_busy", i), {31'd0, bok}, 32'd1);
        end

        for (int i = 0; i < 150; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 3 == 0) begin
                ra[30:23] = 8'($urandom_range(100, 155));
                rb[30:23] = 8'($urandom_range(100, 155));
            end
            model(ra, rb, eo, ef);
            do_op(ra, rb, o, f, lat, bok);
            chk($sformatf("rnd%0d_out", i), o, eo);
            chk($sformatf("rnd%0d_flags", i), {29'd0, f}, {29'd0, ef});
        end

        // start pulsed while busy must be ignored
        @(negedge clk);
        A = 32'h40C00000;
        B = 32'h40000000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        A = 32'h3F800000;
        B = 32'h40400000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("busy_start_done", {31'd0, done}, 32'd1);
        chk("busy_start_out", out, 32'h40400000);
        @(posedge clk);
        #1;
        chk("busy_start_not_queued", {31'd0, busy}, 32'd0);

        // start held high: new op accepted in the done cycle
        @(negedge clk);
        A = 32'h40C00000;
        B = 32'h40000000;
        start = 1'b1;
        lat = 0;
        @(posedge clk);
        #1;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("held_first_out", out, 32'h40400000);
        A = 32'h3F800000;
        B = 32'h40400000;
        @(posedge clk);
        #1;
        chk("held_reaccept", {30'd0, busy, done}, 32'd2);
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        chk("held_second_latency", lat, 26);
        chk("held_second_out", out, 32'h3EAAAAAA);
        @(posedge clk);
        #1;
        chk("held_stop", {31'd0, busy}, 32'd0);

        // reset asserted at E10 aborts the operation
        @(negedge clk);
        A = 32'h40C00000;
        B = 32'h40000000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_out", out, 32'd0);
        chk("abort_ctl", {27'd0, busy, done, overflow, underflow, div_by_zero},
            32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        saw_done = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (done) saw_done++;
        end
        chk("abort_no_done", saw_done, 0);
        do_op(32'hC0C00000, 32'h40000000, o, f, lat, bok);
        chk("after_abort_out", o, 32'hC0400000);
        chk("after_abort_latency", lat, 26);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
